// File: rtl/tmr_cntr_ctrl.sv
// Sequencing controller for an external up/down/load/clear counter forming a
// programmable interval timer with prescaler, one-shot and periodic modes.
module tmr_cntr_ctrl #(
  parameter int n  = 8,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          mode,
  input  logic          dir,
  input  logic [n-1:0]  load_val,
  input  logic [PW-1:0] prescale,
  input  logic [n-1:0]  cnt_count,
  output logic          cnt_clr,
  output logic          cnt_ld,
  output logic          cnt_up,
  output logic [n-1:0]  cnt_D,
  output logic          busy,
  output logic          done,
  output logic          expire
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] pre_q;
  logic [n-1:0]  load_q;
  logic          mode_q;
  logic          dir_q;
  logic          expire_q;

  logic          restart;
  logic          tick;
  logic          at_term;
  logic          hit;
  logic [n-1:0]  term_val;

  // stop outranks start: a simultaneous pair aborts without reloading.
  assign restart  = start && !stop;
  assign tick     = (state_q == RUN) && (presc_q == pre_q) && !pause;
  assign term_val = dir_q ? {n{1'b1}} : {n{1'b0}};
  assign at_term  = (cnt_count == term_val);
  assign hit      = tick && at_term && !stop && !start;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (restart) state_d = RUN;
      end
      RUN: begin
        if (stop)                  state_d = IDLE;
        else if (start)            state_d = RUN;
        else if (hit && !mode_q)   state_d = DONE;
      end
      DONE: begin
        if (stop)                  state_d = IDLE;
        else if (start)            state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter control outputs (combinational, no registered delay)
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_ld = 1'b1;
    cnt_D  = cnt_count;
    if (restart) begin
      cnt_D = load_val;
    end else if (!stop && tick) begin
      if (!at_term)    cnt_ld = 1'b0;
      else if (mode_q) cnt_D  = load_q;
    end
  end

  assign cnt_clr = clr;
  assign cnt_up  = dir_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign expire  = expire_q;

  // ---------------------------------------------------------------------------
  // Prescaler, latched configuration and expire pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      presc_q  <= '0;
      pre_q    <= '0;
      load_q   <= '0;
      mode_q   <= 1'b0;
      dir_q    <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      expire_q <= hit;
      if (restart) begin
        presc_q <= '0;
        pre_q   <= prescale;
        load_q  <= load_val;
        mode_q  <= mode;
        dir_q   <= dir;
      end else if (state_q == RUN && !stop) begin
        // Pause freezes the prescaler so each paused cycle adds one to the period.
        if (tick)        presc_q <= '0;
        else if (!pause) presc_q <= presc_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tmr_cntr_ctrl.sv
// Self-checking bench for tmr_cntr_ctrl driving a behavioural up/down/load/clear
// counter; per-cycle vector table with a scoreboard queue plus timing sequences.
module tb_tmr_cntr_ctrl;

  localparam int N  = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          clr, start, stop, pause, mode, dir;
  logic [N-1:0]  load_val;
  logic [PW-1:0] prescale;
  logic [N-1:0]  cnt_count;
  logic          cnt_clr, cnt_ld, cnt_up;
  logic [N-1:0]  cnt_D;
  logic          busy, done, expire;

  int n_checks = 0;
  int n_fail   = 0;

  tmr_cntr_ctrl #(.n(N), .PW(PW)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .dir(dir), .load_val(load_val), .prescale(prescale),
    .cnt_count(cnt_count), .cnt_clr(cnt_clr), .cnt_ld(cnt_ld),
    .cnt_up(cnt_up), .cnt_D(cnt_D), .busy(busy), .done(done), .expire(expire)
  );

  always #5 clk = ~clk;

  // Attached counter: clear, else load, else step by one.
  always @(posedge clk) begin
    if (cnt_clr)     cnt_count <= '0;
    else if (cnt_ld) cnt_count <= cnt_D;
    else if (cnt_up) cnt_count <= cnt_count + 1'b1;
    else             cnt_count <= cnt_count - 1'b1;
  end

  typedef struct {
    logic          clr, start, stop, pause, mode, dir;
    logic [N-1:0]  load_val;
    logic [PW-1:0] prescale;
    logic [N-1:0]  exp_count;
    logic          exp_busy, exp_done, exp_expire;
  } vec_t;

  typedef struct {
    logic [N-1:0] count;
    logic         busy, done, expire;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t v(input logic c, s, p, pa, m, d, input logic [7:0] lv, pr,
                             input logic [7:0] ec, input logic eb, ed, ee);
    vec_t r;
    r.clr = c; r.start = s; r.stop = p; r.pause = pa; r.mode = m; r.dir = d;
    r.load_val = lv; r.prescale = pr;
    r.exp_count = ec; r.exp_busy = eb; r.exp_done = ed; r.exp_expire = ee;
    return r;
  endfunction

  task automatic drive(input logic c, s, p, pa, m, d, input logic [7:0] lv, pr);
    clr = c; start = s; stop = p; pause = pa; mode = m; dir = d;
    load_val = lv; prescale = pr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    int t_exp[$];
    int first;
    logic [N-1:0] frozen;
    bit seen;

    drive(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);

    //        clr s p pa m d  load   pre    count b d e
    // Reset, then one-shot down load 3 prescale 0; idle config noise must not matter.
    vecs.push_back(v(1,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 0,0,0));
    vecs.push_back(v(0,1,0,0,0,0, 8'h03, 8'h00, 8'h03, 1,0,0));
    vecs.push_back(v(0,0,0,0,1,1, 8'hAA, 8'h05, 8'h02, 1,0,0));
    vecs.push_back(v(0,0,0,0,1,1, 8'h55, 8'h07, 8'h01, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 0,1,1));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 0,1,0));
    // Load at terminal: down, load 0, prescale 2, one-shot; restart from DONE.
    vecs.push_back(v(0,1,0,0,0,0, 8'h00, 8'h02, 8'h00, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 0,1,1));
    // Restart from DONE at 8, then start+stop together at count 7.
    vecs.push_back(v(0,1,0,0,0,0, 8'h08, 8'h00, 8'h08, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'h07, 1,0,0));
    vecs.push_back(v(0,1,1,0,1,1, 8'h55, 8'h00, 8'h07, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'h07, 0,0,0));
    // clr mid-RUN at 0x40 (start also high, clr wins), then load 1 down.
    vecs.push_back(v(0,1,0,0,1,0, 8'h41, 8'h00, 8'h41, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'h40, 1,0,0));
    vecs.push_back(v(1,1,0,0,0,0, 8'h33, 8'h00, 8'h00, 0,0,0));
    vecs.push_back(v(0,1,0,0,0,0, 8'h01, 8'h00, 8'h01, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 0,1,1));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 0,1,0));
    // clr on the terminal tick suppresses the pending expire.
    vecs.push_back(v(0,1,0,0,1,0, 8'h00, 8'h00, 8'h00, 1,0,0));
    vecs.push_back(v(1,0,0,0,0,0, 8'h00, 8'h00, 8'h00, 0,0,0));
    // Periodic up, load FC, prescale 1.
    vecs.push_back(v(0,1,0,0,1,1, 8'hFC, 8'h01, 8'hFC, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'hFC, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'hFD, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'hFD, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'hFE, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'hFE, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'hFF, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'hFF, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'hFC, 1,0,1));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'hFC, 1,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'hFD, 1,0,0));
    vecs.push_back(v(0,0,1,0,0,0, 8'h00, 8'h00, 8'hFD, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,0, 8'h00, 8'h00, 8'hFD, 0,0,0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      exp_t got;
      drive(vecs[i].clr, vecs[i].start, vecs[i].stop, vecs[i].pause,
            vecs[i].mode, vecs[i].dir, vecs[i].load_val, vecs[i].prescale);
      e.count = vecs[i].exp_count; e.busy = vecs[i].exp_busy;
      e.done  = vecs[i].exp_done;  e.expire = vecs[i].exp_expire;
      sb.push_back(e);
      @(posedge clk); #1;
      got = sb.pop_front();
      check($sformatf("v%0d.count", i), cnt_count, got.count);
      check($sformatf("v%0d.busy", i), busy, got.busy);
      check($sformatf("v%0d.done", i), done, got.done);
      check($sformatf("v%0d.expire", i), expire, got.expire);
    end

    // Periodic spacing: three pulses 8 cycles apart, count never reaches 0.
    drive(0, 1, 0, 0, 1, 1, 8'hFC, 8'h01);
    @(posedge clk); #1;
    idle();
    seen = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (cnt_count == 8'h00) seen = 1;
      if (expire) begin
        t_exp.push_back(c);
        check($sformatf("per.reload@%0d", c), cnt_count, 8'hFC);
      end
    end
    check("per.never_zero", seen, 1'b0);
    check("per.pulses", t_exp.size(), 3);
    if (t_exp.size() == 3) begin
      check("per.first", t_exp[0], 8);
      check("per.gap1", t_exp[1] - t_exp[0], 8);
      check("per.gap2", t_exp[2] - t_exp[1], 8);
    end
    drive(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    @(posedge clk); #1;
    check("per.stop_busy", busy, 1'b0);

    // Pause: down, load 5, prescale 2, pause 4 cycles mid-run -> expire at 22.
    drive(0, 1, 0, 0, 0, 0, 8'h05, 8'h02);
    @(posedge clk); #1;
    idle();
    first = -1;
    for (int c = 1; c <= 40 && first < 0; c++) begin
      pause = (c >= 5 && c <= 8);
      if (c == 5) frozen = cnt_count;
      @(posedge clk); #1;
      if (c >= 5 && c <= 8) check($sformatf("pause.frozen@%0d", c), cnt_count, frozen);
      if (expire) first = c;
    end
    pause = 1'b0;
    check("pause.expire_cycle", first, 22);
    check("pause.done", done, 1'b1);
    check("pause.final_count", cnt_count, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
